flexdpe_out_collector: RTL and testbench
========================================

Name: flexdpe_out_collector

Overview:
- Downstream end of the FLEX-DPE output interface.
- Captures each cycle's sparse per-PE result vector (valid mask plus data bus) into a frame buffer.
- Serializes the valid lanes, lowest index first, onto a single-result valid/ready stream toward the output SRAM or writeback logic.
- Absorbs bursts because the FLEX-DPE reduction network cannot be stalled.

Parameters:
- OUT_DATA_TYPE, 32, width of one reduced result (FP32)
- NUM_PES, 32, number of PE lanes in the captured vector
- LOG2_PES, 5, lane index width
- DEPTH, 4, frame buffer entries (power of two)
- LOG2_DEPTH, 2, log2 of DEPTH

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  asynchronous, active-low reset
- i_data_valid  input  NUM_PES  per-lane result valid from FLEX-DPE
- i_data_bus  input  NUM_PES*OUT_DATA_TYPE  per-lane results; lane k at bits [k*OUT_DATA_TYPE +: OUT_DATA_TYPE]
- i_ready  input  1  downstream accepts o_data this cycle
- i_clr_ovf  input  1  synchronous clear of o_overflow
- o_valid  output  1  o_data/o_lane/o_last are valid
- o_data  output  OUT_DATA_TYPE  serialized result
- o_lane  output  LOG2_PES  PE index of o_data
- o_last  output  1  final valid lane of the current frame
- o_overflow  output  1  sticky: a nonzero frame was dropped
- o_occupancy  output  LOG2_DEPTH+1  frames held, 0..DEPTH

Behaviour:
- Reset (rst=0, async):
  - Write pointer, read pointer, count and head remaining-mask all cleared.
  - o_valid=0, o_data=0, o_lane=0, o_last=0, o_overflow=0, o_occupancy=0.
  - Reset mid-drain discards all buffered frames; there is no partial-frame recovery.
- Push: a frame is any cycle where i_data_valid != 0. The mask and the full data bus are written at the buffer tail.
  - All-zero masks are ignored and never stored.
  - Only lanes whose mask bit is set are ever emitted. Data on invalid lanes is don't-care.
- Pop: occurs on the handshake of a beat with o_last=1 (o_valid & i_ready & o_last).
- Full:
  - Push while count==DEPTH and no pop in the same cycle: frame dropped, o_overflow set to 1.
  - Push and pop in the same cycle while full: push accepted, count stays DEPTH, no overflow.
- Overflow flag:
  - o_overflow stays 1 until i_clr_ovf=1.
  - If clear and a new drop occur in the same cycle, the set wins.
- Drain datapath:
  - Head-remaining mask register rmask is loaded from the head entry's mask when the head becomes valid.
  - o_valid = (count != 0).
  - o_lane = index of the lowest set bit of rmask.
  - o_data = head data at lane o_lane.
  - o_last = (rmask has exactly one bit set).
- Drain sequencing:
  - On o_valid & i_ready, the emitted bit is cleared from rmask.
  - If o_last, the frame is popped and rmask reloads from the next entry in the next cycle, with no bubble.
- Outputs: o_data, o_lane and o_last are combinational from registered state (rmask and buffer head). They hold stable while o_valid=1 and i_ready=0.
- Latency: a frame pushed at edge t is visible on o_valid after edge t (first beat in cycle t+1) when the buffer was empty. Sustained throughput is one result per cycle.
- Pointers: read and write pointers wrap modulo DEPTH. Count is kept separately to distinguish full from empty.
- o_occupancy = count. It updates at the same edge as push and pop.

Optional Feature:
- FLEXDPE_COLLECT_CNT_EN
- When defined:
  - Adds output o_drop_count [15:0], reset 0.
  - Increments by 1 on every dropped frame and saturates at 16'hFFFF.
  - Cleared by i_clr_ovf, unless a drop occurs in the same cycle, in which case it loads 1.
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset then single frame: i_data_valid=32'h0000_0081, lane0=0x11, lane7=0x77, i_ready=1 -> next cycle o_lane=0, o_data=0x11, o_last=0; following cycle o_lane=7, o_data=0x77, o_last=1; then o_valid=0, o_occupancy=0.
- Backpressure: same frame, i_ready=0 for 3 cycles -> o_lane=0 and o_data=0x11 held stable, o_occupancy=1; then i_ready=1 -> two beats as above.
- Zero mask: i_data_valid=0 for 5 cycles -> o_occupancy stays 0, o_valid=0, o_overflow=0.
- Overflow: i_ready=0, push 5 nonzero frames with DEPTH=4 -> o_occupancy=4, o_overflow=1, drop_count=1 (with FLEXDPE_COLLECT_CNT_EN); drain yields exactly the first 4 frames in order.
- Full push+pop: buffer full, head frame on its last beat with i_ready=1, and a new nonzero frame arrives -> accepted, o_occupancy stays 4, o_overflow stays 0.
- Async reset mid-drain: assert rst=0 between clock edges during a 32-lane frame -> o_valid drops immediately, o_occupancy=0; after release, a new frame drains from lane 0.

Source files
------------

// File: rtl/flexdpe_out_collector.sv
// Frame collector: buffers sparse per-PE result vectors and serializes valid lanes onto a valid/ready stream.
// Optional FLEXDPE_COLLECT_CNT_EN adds a saturating dropped-frame counter (o_drop_count).
module flexdpe_out_collector #(
    parameter int OUT_DATA_TYPE = 32,
    parameter int NUM_PES       = 32,
    parameter int LOG2_PES      = 5,
    parameter int DEPTH         = 4,
    parameter int LOG2_DEPTH    = 2
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_PES-1:0]                i_data_valid,
    input  logic [NUM_PES*OUT_DATA_TYPE-1:0]  i_data_bus,
    input  logic                              i_ready,
    input  logic                              i_clr_ovf,
    output logic                              o_valid,
    output logic [OUT_DATA_TYPE-1:0]          o_data,
    output logic [LOG2_PES-1:0]               o_lane,
    output logic                              o_last,
    output logic                              o_overflow,
`ifdef FLEXDPE_COLLECT_CNT_EN
    output logic [15:0]                       o_drop_count,
`endif
    output logic [LOG2_DEPTH:0]               o_occupancy
);

    // Handshake: a beat transfers when o_valid & i_ready; the frame retires on the beat with o_last.
    localparam logic [LOG2_DEPTH:0] FULL_CNT = (LOG2_DEPTH+1)'(DEPTH);
    localparam logic [LOG2_DEPTH:0] ONE_CNT  = (LOG2_DEPTH+1)'(1);

    logic [NUM_PES-1:0]               mem_mask [DEPTH];
    logic [NUM_PES*OUT_DATA_TYPE-1:0] mem_data [DEPTH];

    logic [LOG2_DEPTH-1:0] wr_ptr, rd_ptr, rd_ptr_inc;
    logic [LOG2_DEPTH:0]   count, count_nxt;
    logic [NUM_PES-1:0]    rmask, rmask_nxt, low_bit;
    logic [LOG2_PES-1:0]   lane_idx;
    logic                  push, full, hs, pop, drop, push_acc, one_left;

    assign push       = |i_data_valid;
    assign full       = (count == FULL_CNT);
    assign hs         = o_valid & i_ready;
    assign pop        = hs & o_last;
    assign drop       = push & full & ~pop;
    assign push_acc   = push & ~drop;
    assign rd_ptr_inc = rd_ptr + 1'b1;

    assign low_bit  = rmask & (~rmask + NUM_PES'(1));
    assign one_left = (rmask != '0) && ((rmask & (rmask - NUM_PES'(1))) == '0);

    always_comb begin
        lane_idx = '0;
        for (int k = NUM_PES - 1; k >= 0; k--) begin
            if (rmask[k]) lane_idx = LOG2_PES'(k);
        end
    end

    assign o_valid     = (count != '0);
    assign o_lane      = o_valid ? lane_idx : '0;
    assign o_last      = o_valid & one_left;
    assign o_data      = o_valid ? mem_data[rd_ptr][lane_idx*OUT_DATA_TYPE +: OUT_DATA_TYPE] : '0;
    assign o_occupancy = count;

    // On a pop the next head may be the frame arriving this same cycle, so bypass it into rmask.
    always_comb begin
        rmask_nxt = rmask;
        if (pop) begin
            if (count > ONE_CNT)  rmask_nxt = mem_mask[rd_ptr_inc];
            else if (push_acc)    rmask_nxt = i_data_valid;
            else                  rmask_nxt = '0;
        end else if (hs) begin
            rmask_nxt = rmask & ~low_bit;
        end else if (count == '0 && push_acc) begin
            rmask_nxt = i_data_valid;
        end
    end

    always_comb begin
        count_nxt = count;
        case ({push_acc, pop})
            2'b10:   count_nxt = count + ONE_CNT;
            2'b01:   count_nxt = count - ONE_CNT;
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push_acc) begin
            mem_mask[wr_ptr] <= i_data_valid;
            mem_data[wr_ptr] <= i_data_bus;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            rmask      <= '0;
            o_overflow <= 1'b0;
        end else begin
            if (push_acc) wr_ptr <= wr_ptr + 1'b1;
            if (pop)      rd_ptr <= rd_ptr_inc;
            count <= count_nxt;
            rmask <= rmask_nxt;
            if (drop)           o_overflow <= 1'b1;
            else if (i_clr_ovf) o_overflow <= 1'b0;
        end
    end

`ifdef FLEXDPE_COLLECT_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_drop_count <= '0;
        end else if (drop) begin
            if (i_clr_ovf)                  o_drop_count <= 16'd1;
            else if (o_drop_count != '1)    o_drop_count <= o_drop_count + 16'd1;
        end else if (i_clr_ovf) begin
            o_drop_count <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_flexdpe_out_collector.sv
// Bench for flexdpe_out_collector: directed scenarios plus random traffic against an expected-beat queue.
module tb_flexdpe_out_collector;

    localparam int W  = 32;
    localparam int NP = 32;
    localparam int D  = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [NP-1:0]   i_data_valid;
    logic [NP*W-1:0] i_data_bus;
    logic            i_ready;
    logic            i_clr_ovf;
    logic            o_valid;
    logic [W-1:0]    o_data;
    logic [4:0]      o_lane;
    logic            o_last;
    logic            o_overflow;
    logic [2:0]      o_occupancy;
`ifdef FLEXDPE_COLLECT_CNT_EN
    logic [15:0]     o_drop_count;
`endif

    flexdpe_out_collector dut (
        .clk(clk), .rst(rst),
        .i_data_valid(i_data_valid), .i_data_bus(i_data_bus),
        .i_ready(i_ready), .i_clr_ovf(i_clr_ovf),
        .o_valid(o_valid), .o_data(o_data), .o_lane(o_lane), .o_last(o_last),
        .o_overflow(o_overflow),
`ifdef FLEXDPE_COLLECT_CNT_EN
        .o_drop_count(o_drop_count),
`endif
        .o_occupancy(o_occupancy)
    );

    always #5 clk = ~clk;

    // Expected beats in output order: {last, lane[4:0], data[31:0]}
    logic [37:0] exp_q[$];
    int          nframes;
    logic        ovf_m;
    int          drop_m;
    int          checks;
    int          errors;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NP*W-1:0] rand_bus();
        logic [NP*W-1:0] b;
        for (int k = 0; k < NP; k++) b[k*W +: W] = $urandom;
        return b;
    endfunction

    function automatic logic [NP-1:0] rand_mask();
        logic [NP-1:0] m;
        case ($urandom_range(0, 4))
            0:       m = '0;
            1:       m = 32'h1 << $urandom_range(0, NP - 1);
            2:       m = $urandom;
            3:       m = '1;
            default: m = $urandom & $urandom;
        endcase
        return m;
    endfunction

    function automatic logic [NP-1:0] rand_nz_mask();
        logic [NP-1:0] m;
        m = rand_mask();
        if (m == '0) m = 32'h1 << $urandom_range(0, NP - 1);
        return m;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        nframes = 0;
        ovf_m   = 1'b0;
        drop_m  = 0;
    endtask

    // One clock: drive inputs, check outputs against the model mid-cycle, then advance the model at the edge.
    task automatic step(input logic [NP-1:0] mask, input logic [NP*W-1:0] bus,
                        input logic rdy, input logic clr);
        logic [37:0] head;
        bit ev, pop, drop, full_b;
        int hi;
        head = '0;
        i_data_valid = mask;
        i_data_bus   = bus;
        i_ready      = rdy;
        i_clr_ovf    = clr;
        @(negedge clk);
        ev = (exp_q.size() != 0);
        chk("o_valid", o_valid, ev);
        chk("o_occupancy", o_occupancy, nframes);
        chk("o_overflow", o_overflow, ovf_m);
`ifdef FLEXDPE_COLLECT_CNT_EN
        chk("o_drop_count", o_drop_count, drop_m);
`endif
        if (ev) begin
            head = exp_q[0];
            chk("o_lane", o_lane, head[36:32]);
            chk("o_data", o_data, head[31:0]);
            chk("o_last", o_last, head[37]);
        end
        @(posedge clk);
        full_b = (nframes == D);
        pop    = 0;
        drop   = 0;
        if (ev && rdy) begin
            pop = head[37];
            void'(exp_q.pop_front());
            if (pop) nframes--;
        end
        if (mask != '0) begin
            if (full_b && !pop) begin
                drop = 1;
            end else begin
                hi = 0;
                for (int k = 0; k < NP; k++) if (mask[k]) hi = k;
                for (int k = 0; k < NP; k++)
                    if (mask[k]) exp_q.push_back({(k == hi), 5'(k), bus[k*W +: W]});
                nframes++;
            end
        end
        if (drop)     ovf_m = 1'b1;
        else if (clr) ovf_m = 1'b0;
        if (drop)     drop_m = clr ? 1 : ((drop_m == 65535) ? 65535 : drop_m + 1);
        else if (clr) drop_m = 0;
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            step('0, rand_bus(), 1'b1, 1'b0);
            n++;
        end
        chk("drain_bound", exp_q.size(), 0);
        step('0, rand_bus(), 1'b1, 1'b0);
    endtask

    initial begin
        logic [NP*W-1:0] bus;
        checks = 0;
        errors = 0;
        model_reset();
        rst = 1'b0;
        i_data_valid = '0;
        i_data_bus   = '0;
        i_ready      = 1'b0;
        i_clr_ovf    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_o_valid", o_valid, 0);
        chk("rst_o_data", o_data, 0);
        chk("rst_o_lane", o_lane, 0);
        chk("rst_o_last", o_last, 0);
        chk("rst_o_overflow", o_overflow, 0);
        chk("rst_o_occupancy", o_occupancy, 0);
        rst = 1'b1;

        // Single two-lane frame with downstream always ready
        bus = rand_bus();
        bus[0*W +: W] = 32'h11;
        bus[7*W +: W] = 32'h77;
        step(32'h0000_0081, bus, 1'b1, 1'b0);
        repeat (3) step('0, rand_bus(), 1'b1, 1'b0);

        // Backpressure holds the first beat
        step(32'h0000_0081, bus, 1'b0, 1'b0);
        repeat (3) step('0, rand_bus(), 1'b0, 1'b0);
        repeat (3) step('0, rand_bus(), 1'b1, 1'b0);

        // All-zero masks are never stored
        repeat (5) step('0, rand_bus(), 1'($urandom_range(0, 1)), 1'b0);

        // Overflow: five frames into a four-entry buffer
        repeat (5) step(rand_nz_mask(), rand_bus(), 1'b0, 1'b0);
        step('0, rand_bus(), 1'b0, 1'b0);
        step('0, rand_bus(), 1'b1, 1'b1);
        drain();

        // Full buffer, head on its last beat, new frame arrives in the same cycle
        for (int k = 0; k < D; k++) step(32'h1 << (k * 3), rand_bus(), 1'b0, 1'b0);
        step(32'h0000_F000, rand_bus(), 1'b1, 1'b0);
        drain();

        // Async reset in the middle of a 32-lane frame
        step('1, rand_bus(), 1'b1, 1'b0);
        repeat (5) step('0, rand_bus(), 1'b1, 1'b0);
        rst = 1'b0;
        #1;
        chk("midrst_o_valid", o_valid, 0);
        chk("midrst_o_occupancy", o_occupancy, 0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        step(32'h8000_0001, rand_bus(), 1'b1, 1'b0);
        drain();

        // Random traffic with bursts of backpressure and occasional clears
        for (int i = 0; i < 400; i++) begin
            logic rdy;
            rdy = ((i / 40) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            step(rand_mask(), rand_bus(), rdy, ($urandom_range(0, 15) == 0));
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
